// File: rtl/rca_wb_if.sv
// Writeback bundle input, shared register-file write port, retire indication and
// status flags of the RCA result writeback stage.
interface rca_wb_if #(
  parameter int NUM_RESULTS = 5,
  parameter int XLEN        = 32,
  parameter int ID_W        = 3
);
  logic                        in_done;
  logic [ID_W-1:0]             in_id;
  logic [NUM_RESULTS*XLEN-1:0] in_rd;
  logic [NUM_RESULTS*5-1:0]    in_dest_addrs;
  logic                        in_ready;
  logic                        rf_grant;
  logic                        rf_we;
  logic [4:0]                  rf_addr;
  logic [XLEN-1:0]             rf_data;
  logic                        retire_valid;
  logic [ID_W-1:0]             retire_id;
  logic                        busy;
  logic                        overflow;

  modport master (
    output in_done, in_id, in_rd, in_dest_addrs, rf_grant,
    input  in_ready, rf_we, rf_addr, rf_data, retire_valid, retire_id, busy, overflow
  );

  modport slave (
    input  in_done, in_id, in_rd, in_dest_addrs, rf_grant,
    output in_ready, rf_we, rf_addr, rf_data, retire_valid, retire_id, busy, overflow
  );
endinterface

// File: rtl/rca_result_writeback.sv
// Buffers RCA multi-result bundles and drains them one result per cycle onto the
// shared register-file write port, then retires the bundle id.
module rca_result_writeback #(
  parameter int NUM_RESULTS = 5,
  parameter int XLEN        = 32,
  parameter int ID_W        = 3,
  parameter int DEPTH       = 2
) (
  input logic    clk,
  input logic    rst,
  rca_wb_if.slave wb
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (NUM_RESULTS > 1) ? $clog2(NUM_RESULTS) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_RESULTS - 1);

  typedef enum logic [1:0] {IDLE, WRITE, RETIRE} state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] count_q;
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic             overflow_q;

  logic [ID_W-1:0]             id_mem   [DEPTH];
  logic [NUM_RESULTS*XLEN-1:0] rd_mem   [DEPTH];
  logic [NUM_RESULTS*5-1:0]    addr_mem [DEPTH];

  logic            in_ready, push, pop;
  logic [4:0]      head_addr;
  logic [XLEN-1:0] head_data;
  logic            rf_we, retire_valid;
  logic [4:0]      rf_addr;
  logic [XLEN-1:0] rf_data;
  logic [ID_W-1:0] retire_id;

  // Readiness looks at the registered count only, so a pop never frees a slot
  // for a push in the same cycle.
  assign in_ready  = (count_q < DEPTH_C);
  assign push      = wb.in_done && in_ready;
  assign pop       = (state_q == RETIRE);
  assign head_addr = addr_mem[rd_ptr_q][idx_q*5 +: 5];
  assign head_data = rd_mem[rd_ptr_q][idx_q*XLEN +: XLEN];

  // Control state: FIFO pointers/count, drain FSM, sticky overflow
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_q <= count_q + CNT_W'(1);
      else if (pop && !push) count_q <= count_q - CNT_W'(1);
      if (wb.in_done && !in_ready) overflow_q <= 1'b1;
    end
  end

  // Bundle storage carries no reset; validity is tracked by the count alone
  always_ff @(posedge clk) begin
    if (push) begin
      id_mem[wr_ptr_q]   <= wb.in_id;
      rd_mem[wr_ptr_q]   <= wb.in_rd;
      addr_mem[wr_ptr_q] <= wb.in_dest_addrs;
    end
  end

  // Drain FSM: next state and write-port / retire outputs
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    rf_we        = 1'b0;
    rf_addr      = '0;
    rf_data      = '0;
    retire_valid = 1'b0;
    retire_id    = '0;
    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          state_d = WRITE;
          idx_d   = '0;
        end
      end
      WRITE: begin
        rf_addr = head_addr;
        rf_data = head_data;
        rf_we   = (head_addr != 5'd0);
        // x0 results burn a cycle without needing the port
        if (wb.rf_grant || (head_addr == 5'd0)) begin
          if (idx_q == IDX_LAST) state_d = RETIRE;
          else                   idx_d   = idx_q + IDX_W'(1);
        end
      end
      RETIRE: begin
        retire_valid = 1'b1;
        retire_id    = id_mem[rd_ptr_q];
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign wb.in_ready     = in_ready;
  assign wb.rf_we        = rf_we;
  assign wb.rf_addr      = rf_addr;
  assign wb.rf_data      = rf_data;
  assign wb.retire_valid = retire_valid;
  assign wb.retire_id    = retire_id;
  assign wb.busy         = (count_q != '0) || (state_q != IDLE);
  assign wb.overflow     = overflow_q;
endmodule

// File: tb/tb_rca_result_writeback.sv
// Scoreboard bench for rca_result_writeback: expected writes/retires are queued at
// issue time from a transaction-level model and popped by an output monitor.
module tb_rca_result_writeback;
  localparam int NR    = 5;
  localparam int XL    = 32;
  localparam int IW    = 3;
  localparam int DEPTH = 2;
  localparam int MAXC  = 4096;

  typedef logic [NR*XL-1:0] rd_t;
  typedef logic [NR*5-1:0]  ad_t;
  typedef struct {
    bit            is_retire;
    logic [4:0]    addr;
    logic [XL-1:0] data;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  ev_t  exp_q[$];
  ev_t  mon_e;
  int   acc_cnt = 0;
  int   ret_cnt = 0;
  bit   exp_ready = 1'b1;
  bit   exp_ovf = 1'b0;
  bit   ovf_pend = 1'b0;

  logic [XL-1:0] rf_mem [32];
  logic          snap_we   [MAXC];
  logic [4:0]    snap_addr [MAXC];
  logic [XL-1:0] snap_data [MAXC];
  logic          snap_ret  [MAXC];
  logic [IW-1:0] snap_rid  [MAXC];
  logic          snap_busy [MAXC];
  logic          snap_rdy  [MAXC];
  logic          snap_ovf  [MAXC];

  rca_wb_if #(.NUM_RESULTS(NR), .XLEN(XL), .ID_W(IW)) wb ();

  rca_result_writeback #(.NUM_RESULTS(NR), .XLEN(XL), .ID_W(IW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (wb)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [XL-1:0] act, input logic [XL-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h, required %0h", nm, cyc, act, req);
    end
  endtask

  // Transaction model: every nonzero destination is written in index order, then the id retires.
  task automatic model_push(input logic [IW-1:0] id, input rd_t rd, input ad_t ad);
    ev_t e;
    for (int i = 0; i < NR; i++) begin
      if (ad[i*5 +: 5] != 5'd0) begin
        e.is_retire = 1'b0;
        e.addr      = ad[i*5 +: 5];
        e.data      = rd[i*XL +: XL];
        exp_q.push_back(e);
      end
    end
    e.is_retire = 1'b1;
    e.addr      = 5'd0;
    e.data      = XL'(id);
    exp_q.push_back(e);
  endtask

  // One clock of stimulus; acceptance is predicted from bundles held (accepted minus retired).
  task automatic step(input bit r, input bit done, input logic [IW-1:0] id,
                      input rd_t rd, input ad_t ad, input bit grant);
    @(posedge clk);
    #2;
    rst              = r;
    wb.in_done       = done;
    wb.in_id         = id;
    wb.in_rd         = rd;
    wb.in_dest_addrs = ad;
    wb.rf_grant      = grant;
    if (r) begin
      exp_q.delete();
      acc_cnt   = 0;
      ret_cnt   = 0;
      exp_ovf   = 1'b0;
      ovf_pend  = 1'b0;
      exp_ready = 1'b1;
    end else begin
      exp_ovf   = exp_ovf | ovf_pend;
      ovf_pend  = 1'b0;
      exp_ready = ((acc_cnt - ret_cnt) < DEPTH);
      if (done) begin
        if (exp_ready) begin
          model_push(id, rd, ad);
          acc_cnt++;
        end else begin
          ovf_pend = 1'b1;
        end
      end
    end
  endtask

  task automatic idle(input int n, input bit grant);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0, grant);
  endtask

  // Output monitor / scoreboard
  always @(negedge clk) begin
    if (cyc < MAXC) begin
      snap_we[cyc]   = wb.rf_we;
      snap_addr[cyc] = wb.rf_addr;
      snap_data[cyc] = wb.rf_data;
      snap_ret[cyc]  = wb.retire_valid;
      snap_rid[cyc]  = wb.retire_id;
      snap_busy[cyc] = wb.busy;
      snap_rdy[cyc]  = wb.in_ready;
      snap_ovf[cyc]  = wb.overflow;
    end
    if (rst === 1'b0) begin
      chk("in_ready", XL'(wb.in_ready), XL'(exp_ready));
      chk("overflow", XL'(wb.overflow), XL'(exp_ovf));
      if (wb.rf_we && wb.rf_grant) begin
        rf_mem[wb.rf_addr] = wb.rf_data;
        if (exp_q.size() == 0) begin
          chk("unexpected_write_addr", XL'(wb.rf_addr), XL'(0));
        end else begin
          mon_e = exp_q.pop_front();
          chk("write_vs_retire", XL'(mon_e.is_retire), XL'(0));
          chk("write_addr", XL'(wb.rf_addr), XL'(mon_e.addr));
          chk("write_data", wb.rf_data, mon_e.data);
        end
      end
      if (wb.retire_valid) begin
        ret_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_retire_id", XL'(wb.retire_id), XL'({IW{1'b1}}) + 1);
        end else begin
          mon_e = exp_q.pop_front();
          chk("retire_vs_write", XL'(mon_e.is_retire), XL'(1));
          chk("retire_id", XL'(wb.retire_id), mon_e.data);
        end
      end
    end
  end

  initial begin
    rd_t rd;
    ad_t ad;
    int  t;
    bit  d;

    wb.in_done = 1'b0; wb.in_id = '0; wb.in_rd = '0; wb.in_dest_addrs = '0; wb.rf_grant = 1'b0;
    for (int i = 0; i < 32; i++) rf_mem[i] = '0;

    repeat (3) step(1'b1, 1'b0, '0, '0, '0, 1'b0);
    step(1'b0, 1'b0, '0, '0, '0, 1'b1);
    @(negedge clk);
    chk("rst_rf_we",        XL'(wb.rf_we), XL'(0));
    chk("rst_rf_addr",      XL'(wb.rf_addr), XL'(0));
    chk("rst_rf_data",      wb.rf_data, XL'(0));
    chk("rst_retire_valid", XL'(wb.retire_valid), XL'(0));
    chk("rst_retire_id",    XL'(wb.retire_id), XL'(0));
    chk("rst_busy",         XL'(wb.busy), XL'(0));
    chk("rst_in_ready",     XL'(wb.in_ready), XL'(1));

    // Single bundle, sequential addresses, grant always on
    for (int i = 0; i < NR; i++) begin rd[i*XL +: XL] = $urandom; ad[i*5 +: 5] = 5'(i + 1); end
    step(1'b0, 1'b1, 3'd3, rd, ad, 1'b1);
    t = cyc;
    idle(9, 1'b1);
    chk("t1_no_early_we", XL'(snap_we[t+1]), XL'(0));
    chk("t1_busy_idle",   XL'(snap_busy[t+1]), XL'(1));
    for (int k = 0; k < NR; k++) begin
      chk("t1_we",   XL'(snap_we[t+2+k]), XL'(1));
      chk("t1_addr", XL'(snap_addr[t+2+k]), XL'(k + 1));
      chk("t1_data", snap_data[t+2+k], rd[k*XL +: XL]);
    end
    chk("t1_retire",    XL'(snap_ret[t+7]), XL'(1));
    chk("t1_retire_id", XL'(snap_rid[t+7]), XL'(3));
    chk("t1_busy_low",  XL'(snap_busy[t+8]), XL'(0));

    // Zero destinations skip the port
    for (int i = 0; i < NR; i++) rd[i*XL +: XL] = $urandom;
    ad = {5'd9, 5'd0, 5'd0, 5'd7, 5'd0};
    step(1'b0, 1'b1, 3'd4, rd, ad, 1'b1);
    t = cyc;
    idle(9, 1'b1);
    chk("t2_we0", XL'(snap_we[t+2]), XL'(0));
    chk("t2_we1", XL'(snap_we[t+3]), XL'(1));
    chk("t2_a1",  XL'(snap_addr[t+3]), XL'(7));
    chk("t2_we2", XL'(snap_we[t+4]), XL'(0));
    chk("t2_we3", XL'(snap_we[t+5]), XL'(0));
    chk("t2_we4", XL'(snap_we[t+6]), XL'(1));
    chk("t2_a4",  XL'(snap_addr[t+6]), XL'(9));
    chk("t2_retire", XL'(snap_ret[t+7]), XL'(1));

    // Grant withheld for three cycles while idx1 is pending
    for (int i = 0; i < NR; i++) begin rd[i*XL +: XL] = $urandom; ad[i*5 +: 5] = 5'(i + 1); end
    step(1'b0, 1'b1, 3'd5, rd, ad, 1'b1);
    t = cyc;
    idle(2, 1'b1);
    idle(3, 1'b0);
    idle(8, 1'b1);
    for (int k = 3; k <= 6; k++) begin
      chk("t3_hold_we",   XL'(snap_we[t+k]), XL'(1));
      chk("t3_hold_addr", XL'(snap_addr[t+k]), XL'(2));
      chk("t3_hold_data", snap_data[t+k], rd[XL +: XL]);
    end
    chk("t3_no_early_retire", XL'(snap_ret[t+7]), XL'(0));
    chk("t3_retire",          XL'(snap_ret[t+10]), XL'(1));

    // Duplicate destinations: highest index lands last
    for (int i = 0; i < NR; i++) begin rd[i*XL +: XL] = XL'(10 + i); ad[i*5 +: 5] = 5'd6; end
    step(1'b0, 1'b1, 3'd6, rd, ad, 1'b1);
    t = cyc;
    idle(9, 1'b1);
    for (int k = 0; k < NR; k++) chk("t6_addr", XL'(snap_addr[t+2+k]), XL'(6));
    chk("t6_final_x6", rf_mem[6], XL'(14));

    // Back-to-back ids 1,2,3 into a two-entry FIFO
    for (int i = 0; i < NR; i++) begin rd[i*XL +: XL] = $urandom; ad[i*5 +: 5] = 5'(i + 11); end
    step(1'b0, 1'b1, 3'd1, rd, ad, 1'b1);
    t = cyc;
    step(1'b0, 1'b1, 3'd2, rd, ad, 1'b1);
    step(1'b0, 1'b1, 3'd3, rd, ad, 1'b1);
    idle(20, 1'b1);
    chk("t4_ready_low", XL'(snap_rdy[t+2]), XL'(0));
    chk("t4_overflow",  XL'(snap_ovf[t+3]), XL'(1));
    chk("t4_ret1",      XL'(snap_ret[t+7]), XL'(1));
    chk("t4_ret1_id",   XL'(snap_rid[t+7]), XL'(1));
    chk("t4_ret2",      XL'(snap_ret[t+14]), XL'(1));
    chk("t4_ret2_id",   XL'(snap_rid[t+14]), XL'(2));
    for (int k = 15; k <= 21; k++) chk("t4_no_ret3", XL'(snap_ret[t+k]), XL'(0));

    // Reset while idx2 is on the port
    for (int i = 0; i < NR; i++) begin rd[i*XL +: XL] = $urandom; ad[i*5 +: 5] = 5'(i + 1); end
    step(1'b0, 1'b1, 3'd7, rd, ad, 1'b1);
    t = cyc;
    idle(3, 1'b1);
    step(1'b1, 1'b0, '0, '0, '0, 1'b1);
    idle(8, 1'b1);
    chk("t5_idx2_addr", XL'(snap_addr[t+4]), XL'(3));
    chk("t5_we_after",   XL'(snap_we[t+5]), XL'(0));
    chk("t5_busy_after", XL'(snap_busy[t+5]), XL'(0));
    chk("t5_rdy_after",  XL'(snap_rdy[t+5]), XL'(1));
    chk("t5_ovf_after",  XL'(snap_ovf[t+5]), XL'(0));
    for (int k = 5; k <= 11; k++) chk("t5_no_retire", XL'(snap_ret[t+k]), XL'(0));
    for (int i = 0; i < NR; i++) rd[i*XL +: XL] = $urandom;
    step(1'b0, 1'b1, 3'd2, rd, ad, 1'b1);
    t = cyc;
    idle(9, 1'b1);
    chk("t5_fresh_retire",    XL'(snap_ret[t+7]), XL'(1));
    chk("t5_fresh_retire_id", XL'(snap_rid[t+7]), XL'(2));

    // Randomized traffic with random grant and sparse/duplicate destinations
    for (int n = 0; n < 300; n++) begin
      d = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < NR; i++) begin
        rd[i*XL +: XL] = $urandom;
        ad[i*5 +: 5]   = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 8));
      end
      step(1'b0, d, IW'($urandom), rd, ad, ($urandom_range(0, 9) < 7));
    end
    for (int n = 0; n < 400 && exp_q.size() != 0; n++) step(1'b0, 1'b0, '0, '0, '0, 1'b1);
    idle(2, 1'b1);
    chk("drain_outstanding", XL'(exp_q.size()), XL'(0));
    @(negedge clk);
    chk("final_busy", XL'(wb.busy), XL'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
